// File: rtl/prog_sequencer.sv
// Program sequencer: launches programs 0..NUM_PROGS-1 on the fetch unit through its Init/DONE handshake
// and records each run length. Optional watchdog compiled in with PROG_SEQ_TIMEOUT_EN.
module prog_sequencer #(
  parameter int unsigned NUM_PROGS      = 3,
  parameter int unsigned INIT_CYCLES    = 2,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start_req,
  input  logic             Done_in,
  input  logic [15:0]      PC_in,
  output logic             Init_out,
  output logic [1:0]       Prog_idx,
  output logic             Busy,
  output logic             All_done,
  output logic [CNT_W-1:0] Cycle_count,
  output logic             Timeout
);

  localparam int unsigned      INIT_W      = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic [CNT_W-1:0]  run_cnt;
  logic [15:0]       pc_prev;
  logic              complete, timeout_hit, finish, init_last;

  // run_cnt >= 2 masks the DONE still asserted from the previous program.
  assign complete  = (state == S_RUN) && Done_in && (PC_in == pc_prev) && (run_cnt >= CNT_W'(2));
  assign init_last = (init_cnt == INIT_W'(INIT_CYCLES - 1));

`ifdef PROG_SEQ_TIMEOUT_EN
  assign timeout_hit = (state == S_RUN) && !complete && (run_cnt >= TIMEOUT_LIM);
`else
  assign timeout_hit = 1'b0;
`endif

  assign finish   = complete || timeout_hit;
  assign Init_out = (state != S_RUN);
  assign Busy     = (state != S_IDLE);

  // NOTE: sequential state is written with non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start_req && !All_done) state_nxt = S_INIT;
      S_INIT:  if (init_last)              state_nxt = S_RUN;
      S_RUN:   if (finish)                 state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      init_cnt    <= '0;
      run_cnt     <= '0;
      pc_prev     <= '0;
      Prog_idx    <= '0;
      All_done    <= 1'b0;
      Cycle_count <= '0;
      Timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: init_cnt <= '0;
        S_INIT: begin
          init_cnt <= init_cnt + INIT_W'(1);
          run_cnt  <= '0;
        end
        S_RUN: begin
          if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
          pc_prev <= PC_in;
          if (finish) begin
            Cycle_count <= timeout_hit ? TIMEOUT_LIM : run_cnt;
            if (timeout_hit) Timeout <= 1'b1;
            if (Prog_idx == 2'(NUM_PROGS - 1)) All_done <= 1'b1;
            else                               Prog_idx <= Prog_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a small fetch-unit model supplies PC/DONE, expected completions
// are queued at launch and checked by a monitor whenever Busy falls outside reset.
module tb_prog_sequencer;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start_req = 1'b0;
  logic        Done_in;
  logic [15:0] PC_in;
  logic        Init_out, Busy, All_done, Timeout;
  logic [1:0]  Prog_idx;
  logic [31:0] Cycle_count;

  prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(2), .CNT_W(32), .TIMEOUT_CYCLES(50)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start_req(Start_req), .Done_in(Done_in), .PC_in(PC_in),
    .Init_out(Init_out), .Prog_idx(Prog_idx), .Busy(Busy), .All_done(All_done),
    .Cycle_count(Cycle_count), .Timeout(Timeout)
  );

  always #5 CLK = ~CLK;

  // Fetch-unit model: PC cleared while Init is high, counts up to m_halt, DONE sticky until m_clr.
  logic [15:0] m_pc = 16'd0;
  logic [15:0] m_halt = 16'd0;
  logic        m_done = 1'b0;
  logic        m_done_en = 1'b1;
  logic        m_clr = 1'b0;

  always @(posedge CLK) begin
    if (Init_out)            m_pc <= 16'd0;
    else if (m_pc != m_halt) m_pc <= m_pc + 16'd1;
    if (m_clr)                                         m_done <= 1'b0;
    else if (m_done_en && !Init_out && m_pc == m_halt) m_done <= 1'b1;
  end
  assign PC_in   = m_pc;
  assign Done_in = m_done;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] cc;
    logic        all;
    logic        to;
  } exp_t;
  exp_t sb[$];

  // Monitor: a Busy 1->0 transition with reset released is a program completion.
  logic prev_busy = 1'b0;
  always @(negedge CLK) begin
    if (prev_busy && !Busy && Reset_n) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_completion: got Cycle_count=%0d Prog_idx=%0d expected none", Cycle_count, Prog_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_prog_idx", 32'(Prog_idx), 32'(e.idx));
        check("done_cycle_count", Cycle_count, e.cc);
        check("done_all_done", 32'(All_done), 32'(e.all));
        check("done_timeout", 32'(Timeout), 32'(e.to));
        check("done_init_out", 32'(Init_out), 32'd1);
      end
    end
    prev_busy = Busy;
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    Reset_n = 1'b0;
    m_clr   = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    m_clr   = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 Start_req = 1'b1;
    @(posedge CLK); #1 Start_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge CLK);
    check({tag, "_init_out"}, 32'(Init_out), 32'd1);
    check({tag, "_prog_idx"}, 32'(Prog_idx), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_all_done"}, 32'(All_done), 32'd0);
    check({tag, "_cycle_count"}, Cycle_count, 32'd0);
    check({tag, "_timeout"}, 32'(Timeout), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Busy && n < max_cycles);
    check(name, 32'(Busy), 32'd0);
  endtask

  // Launch a program halting at PC=halt, push its expected completion, wait for it.
  task automatic run_prog(input string name, input logic [15:0] halt, input exp_t e);
    m_halt = halt;
    sb.push_back(e);
    pulse_start();
    wait_idle(name, 1000);
  endtask

  initial begin
    exp_t e;

    // 1. reset
    do_reset();
    check_reset_values("rst");

    // 2. program 0: Init timing then halt at PC=123 -> 124 run cycles
    m_halt = 16'd123;
    e = '{idx: 2'd1, cc: 32'd124, all: 1'b0, to: 1'b0};
    sb.push_back(e);
    pulse_start();
    @(negedge CLK);
    check("init0_init_out", 32'(Init_out), 32'd1);
    check("init0_busy", 32'(Busy), 32'd1);
    @(negedge CLK);
    check("init1_init_out", 32'(Init_out), 32'd1);
    @(negedge CLK);
    check("run0_init_out", 32'(Init_out), 32'd0);
    check("run0_busy", 32'(Busy), 32'd1);
    wait_idle("prog0_idle", 1000);

    // 3. program 1 with DONE still set; halt at PC=300 -> 301
    e = '{idx: 2'd2, cc: 32'd301, all: 1'b0, to: 1'b0};
    run_prog("prog1_idle", 16'd300, e);

    // 4. program 2 halts immediately at PC=0: stale DONE masked until run_cnt==2
    e = '{idx: 2'd2, cc: 32'd2, all: 1'b1, to: 1'b0};
    run_prog("prog2_idle", 16'd0, e);

    // Start after All_done is ignored
    pulse_start();
    repeat (3) begin
      @(negedge CLK);
      check("alldone_busy", 32'(Busy), 32'd0);
    end
    check("alldone_prog_idx", 32'(Prog_idx), 32'd2);
    check("alldone_all_done", 32'(All_done), 32'd1);

    // 5. self-branch without DONE, Start during RUN, reset mid-RUN
    do_reset();
    check_reset_values("rst2");
    m_done_en = 1'b0;
    m_halt    = 16'd5;
    pulse_start();
    repeat (12) @(negedge CLK);
    pulse_start();
    repeat (3) begin
      @(negedge CLK);
      check("run_start_ignored_busy", 32'(Busy), 32'd1);
      check("run_start_ignored_init", 32'(Init_out), 32'd0);
    end
    do_reset();
    check_reset_values("rst_midrun");

    // 6. watchdog
    pulse_start();
`ifdef PROG_SEQ_TIMEOUT_EN
    e = '{idx: 2'd1, cc: 32'd50, all: 1'b0, to: 1'b1};
    sb.push_back(e);
    wait_idle("timeout_idle", 200);
`else
    repeat (80) @(negedge CLK);
    check("no_wd_busy", 32'(Busy), 32'd1);
    check("no_wd_timeout", 32'(Timeout), 32'd0);
    check("no_wd_cycle_count", Cycle_count, 32'd0);
`endif

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
